// File: rtl/ss_seq.sv
// Save-state sequencer: walks the mapper save-state register range. A save
// copies mapper registers into the state buffer; a load restores them. Mapper
// writes are held across a full m2 period, so the mapper's m2-falling write
// latch always sees a stable address and stable data.
module ss_seq #(
  parameter int unsigned SS_FIRST = 0,
  parameter int unsigned SS_LAST  = 127,
  parameter int unsigned SETTLE   = 2,
  parameter int unsigned TMO      = 4095
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       dir,
  input  logic       m2_fall,
  output logic       ss_act,
  output logic       ss_we,
  output logic [7:0] ss_addr,
  output logic [7:0] ss_wdat,
  input  logic [7:0] ss_rdat,
  output logic [7:0] buf_addr,
  output logic       buf_we,
  output logic [7:0] buf_wdat,
  output logic       buf_rd,
  input  logic       buf_rdy,
  input  logic [7:0] buf_rdat,
  output logic       busy,
  output logic       done,
  output logic       err
);

  // The timeout counter holds 0..TMO-1; reaching the last value with no
  // m2 fall is the abort condition.
  localparam int unsigned TMO_W = (TMO < 2) ? 1 : $clog2(TMO);
  localparam logic [TMO_W-1:0] TMO_LAST    = TMO_W'(TMO - 1);
  localparam logic [TMO_W-1:0] TMO_ZERO    = TMO_W'(0);
  localparam logic [TMO_W-1:0] TMO_ONE     = TMO_W'(1);
  localparam logic [7:0]       FIRST_A     = 8'(SS_FIRST);
  localparam logic [7:0]       LAST_A      = 8'(SS_LAST);
  localparam logic [3:0]       SETTLE_LAST = 4'(SETTLE - 1);

  typedef enum logic [3:0] {
    IDLE      = 4'd0,
    ARM       = 4'd1,
    S_SETTLE  = 4'd2,
    S_STORE   = 4'd3,
    L_FETCH   = 4'd4,
    L_PRESENT = 4'd5,
    L_LATCH   = 4'd6,
    NEXT      = 4'd7,
    FIN       = 4'd8
  } state_t;

  state_t           state_r,    state_s;
  logic             dir_r,      dir_s;
  logic             ss_act_r,   ss_act_s;
  logic             ss_we_r,    ss_we_s;
  logic [7:0]       ss_addr_r,  ss_addr_s;
  logic [7:0]       ss_wdat_r,  ss_wdat_s;
  logic [7:0]       buf_addr_r, buf_addr_s;
  logic             buf_we_r,   buf_we_s;
  logic [7:0]       buf_wdat_r, buf_wdat_s;
  logic             buf_rd_r,   buf_rd_s;
  logic             busy_r,     busy_s;
  logic             done_r,     done_s;
  logic             err_r,      err_s;
  logic [3:0]       settle_r,   settle_s;
  logic [TMO_W-1:0] tmo_r,      tmo_s;
  logic             tmo_hit_s;

  // Next-state and next-output logic; every output is registered below.
  always_comb begin
    state_s    = state_r;
    dir_s      = dir_r;
    ss_act_s   = ss_act_r;
    ss_we_s    = ss_we_r;
    ss_addr_s  = ss_addr_r;
    ss_wdat_s  = ss_wdat_r;
    buf_addr_s = buf_addr_r;
    buf_we_s   = 1'b0;
    buf_wdat_s = buf_wdat_r;
    buf_rd_s   = buf_rd_r;
    busy_s     = busy_r;
    done_s     = 1'b0;
    err_s      = err_r;
    settle_s   = settle_r;
    tmo_s      = tmo_r;
    tmo_hit_s  = (tmo_r == TMO_LAST);

    case (state_r)
      IDLE: begin
        if (start) begin
          dir_s      = dir;
          err_s      = 1'b0;
          busy_s     = 1'b1;
          ss_addr_s  = FIRST_A;
          buf_addr_s = 8'd0;
          tmo_s      = TMO_ZERO;
          state_s    = ARM;
        end else begin
          state_s    = IDLE;
        end
      end

      // Access only opens right after an m2 fall so a CPU write in flight
      // is never overlapped.
      ARM: begin
        if (m2_fall) begin
          ss_act_s = 1'b1;
          if (dir_r) begin
            buf_rd_s = 1'b1;
            state_s  = L_FETCH;
          end else begin
            settle_s = 4'd0;
            state_s  = S_SETTLE;
          end
        end else if (tmo_hit_s) begin
          err_s    = 1'b1;
          ss_we_s  = 1'b0;
          ss_act_s = 1'b0;
          busy_s   = 1'b0;
          buf_rd_s = 1'b0;
          state_s  = IDLE;
        end else begin
          tmo_s    = tmo_r + TMO_ONE;
        end
      end

      // Readback is sampled at the end of the last settle cycle and the
      // buffer write strobe is presented during S_STORE.
      S_SETTLE: begin
        if (settle_r == SETTLE_LAST) begin
          buf_we_s   = 1'b1;
          buf_wdat_s = ss_rdat;
          state_s    = S_STORE;
        end else begin
          settle_s   = settle_r + 4'd1;
        end
      end

      S_STORE: begin
        state_s = NEXT;
      end

      // An m2 fall in the same cycle as buf_rdy is deliberately not counted.
      L_FETCH: begin
        if (buf_rdy) begin
          buf_rd_s  = 1'b0;
          ss_wdat_s = buf_rdat;
          ss_we_s   = 1'b1;
          tmo_s     = TMO_ZERO;
          state_s   = L_PRESENT;
        end else begin
          state_s   = L_FETCH;
        end
      end

      // First m2 fall aligns ss_we to the start of a full m2 period.
      L_PRESENT: begin
        if (m2_fall) begin
          tmo_s   = TMO_ZERO;
          state_s = L_LATCH;
        end else if (tmo_hit_s) begin
          err_s    = 1'b1;
          ss_we_s  = 1'b0;
          ss_act_s = 1'b0;
          busy_s   = 1'b0;
          state_s  = IDLE;
        end else begin
          tmo_s    = tmo_r + TMO_ONE;
        end
      end

      // The mapper latches on this m2 fall; ss_we drops the cycle after.
      L_LATCH: begin
        if (m2_fall) begin
          ss_we_s = 1'b0;
          state_s = NEXT;
        end else if (tmo_hit_s) begin
          err_s    = 1'b1;
          ss_we_s  = 1'b0;
          ss_act_s = 1'b0;
          busy_s   = 1'b0;
          state_s  = IDLE;
        end else begin
          tmo_s    = tmo_r + TMO_ONE;
        end
      end

      // ">=" also ends an inverted range after its single access at
      // SS_FIRST and keeps the address from ever wrapping.
      NEXT: begin
        if (ss_addr_r >= LAST_A) begin
          ss_act_s   = 1'b0;
          busy_s     = 1'b0;
          done_s     = 1'b1;
          ss_addr_s  = FIRST_A;
          buf_addr_s = 8'd0;
          state_s    = FIN;
        end else begin
          ss_addr_s  = ss_addr_r + 8'd1;
          buf_addr_s = buf_addr_r + 8'd1;
          if (dir_r) begin
            buf_rd_s = 1'b1;
            state_s  = L_FETCH;
          end else begin
            settle_s = 4'd0;
            state_s  = S_SETTLE;
          end
        end
      end

      FIN: begin
        state_s = IDLE;
      end

      default: begin
        ss_act_s = 1'b0;
        ss_we_s  = 1'b0;
        buf_rd_s = 1'b0;
        busy_s   = 1'b0;
        state_s  = IDLE;
      end
    endcase
  end

  // State and output registers; reset drops every strobe immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= IDLE;
      dir_r      <= 1'b0;
      ss_act_r   <= 1'b0;
      ss_we_r    <= 1'b0;
      ss_addr_r  <= FIRST_A;
      ss_wdat_r  <= 8'd0;
      buf_addr_r <= 8'd0;
      buf_we_r   <= 1'b0;
      buf_wdat_r <= 8'd0;
      buf_rd_r   <= 1'b0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      err_r      <= 1'b0;
      settle_r   <= 4'd0;
      tmo_r      <= TMO_ZERO;
    end else begin
      state_r    <= state_s;
      dir_r      <= dir_s;
      ss_act_r   <= ss_act_s;
      ss_we_r    <= ss_we_s;
      ss_addr_r  <= ss_addr_s;
      ss_wdat_r  <= ss_wdat_s;
      buf_addr_r <= buf_addr_s;
      buf_we_r   <= buf_we_s;
      buf_wdat_r <= buf_wdat_s;
      buf_rd_r   <= buf_rd_s;
      busy_r     <= busy_s;
      done_r     <= done_s;
      err_r      <= err_s;
      settle_r   <= settle_s;
      tmo_r      <= tmo_s;
    end
  end

  assign ss_act   = ss_act_r;
  assign ss_we    = ss_we_r;
  assign ss_addr  = ss_addr_r;
  assign ss_wdat  = ss_wdat_r;
  assign buf_addr = buf_addr_r;
  assign buf_we   = buf_we_r;
  assign buf_wdat = buf_wdat_r;
  assign buf_rd   = buf_rd_r;
  assign busy     = busy_r;
  assign done     = done_r;
  assign err      = err_r;

endmodule

// File: tb/tb_ss_seq.sv
// Bench for ss_seq: a mapper register file and a state buffer are modelled
// as arrays. Expected results come from the range rules: a save copies
// mapper[FIRST..LAST] to buffer[0..], and a load copies them back.
module tb_ss_seq;
  localparam int TMO_T = 64;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       start, dir, m2_fall, buf_rdy;
  logic [7:0] ss_rdat, buf_rdat;
  logic       ss_act, ss_we, buf_we, buf_rd, busy, done, err;
  logic [7:0] ss_addr, ss_wdat, buf_addr, buf_wdat;

  logic       start_b;
  logic [7:0] ss_rdat_b, map_idx;
  logic       ss_act_b, ss_we_b, buf_we_b, buf_rd_b, busy_b, done_b, err_b;
  logic [7:0] ss_addr_b, ss_wdat_b, buf_addr_b, buf_wdat_b;

  logic [7:0] mreg [0:255];
  logic [7:0] bufm [0:255];

  int n_chk = 0;
  int n_fail = 0;

  ss_seq #(.SS_FIRST(0), .SS_LAST(13), .SETTLE(2), .TMO(TMO_T)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .dir(dir), .m2_fall(m2_fall),
    .ss_act(ss_act), .ss_we(ss_we), .ss_addr(ss_addr), .ss_wdat(ss_wdat),
    .ss_rdat(ss_rdat), .buf_addr(buf_addr), .buf_we(buf_we), .buf_wdat(buf_wdat),
    .buf_rd(buf_rd), .buf_rdy(buf_rdy), .buf_rdat(buf_rdat),
    .busy(busy), .done(done), .err(err)
  );

  ss_seq #(.SS_FIRST(127), .SS_LAST(127), .SETTLE(3), .TMO(TMO_T)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .dir(1'b0), .m2_fall(m2_fall),
    .ss_act(ss_act_b), .ss_we(ss_we_b), .ss_addr(ss_addr_b), .ss_wdat(ss_wdat_b),
    .ss_rdat(ss_rdat_b), .buf_addr(buf_addr_b), .buf_we(buf_we_b), .buf_wdat(buf_wdat_b),
    .buf_rd(buf_rd_b), .buf_rdy(1'b0), .buf_rdat(8'h00),
    .busy(busy_b), .done(done_b), .err(err_b)
  );

  assign ss_rdat   = mreg[ss_addr];
  assign ss_rdat_b = (ss_addr_b == 8'd127) ? map_idx : 8'h00;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // m2 strobe generator; m2_kill stalls it while register 5 is in progress
  int   m2_per = 6;
  int   m2_ph = 0;
  logic m2_kill = 1'b0;
  initial begin
    m2_fall = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (!(m2_kill && busy && ss_addr == 8'd5) && m2_ph >= m2_per - 1) begin
        m2_fall = 1'b1;
        m2_ph = 0;
      end else begin
        m2_fall = 1'b0;
        if (m2_ph < m2_per) m2_ph++;
      end
    end
  end

  // state buffer read responder with fixed or random latency and optional
  // stray buf_rdy pulses while no read is pending
  int   lat_fix = 3;
  logic lat_rand = 1'b0;
  logic spur_en = 1'b0;
  int   rcnt = 0;
  int   lat_cur = 3;
  initial begin
    buf_rdy = 1'b0;
    buf_rdat = 8'h00;
    forever begin
      @(posedge clk); #1;
      if (!rst_n) begin
        buf_rdy = 1'b0; rcnt = 0;
      end else if (buf_rdy) begin
        buf_rdy = 1'b0; rcnt = 0; buf_rdat = 8'h00;
      end else if (buf_rd) begin
        if (rcnt == 0) lat_cur = lat_rand ? int'($urandom_range(1, 5)) : lat_fix;
        if (rcnt >= lat_cur) begin
          buf_rdy = 1'b1; buf_rdat = bufm[buf_addr];
        end else begin
          rcnt++;
        end
      end else begin
        rcnt = 0;
        if (spur_en && $urandom_range(0, 7) == 0) begin
          buf_rdy = 1'b1; buf_rdat = 8'hEE;
        end
      end
    end
  end

  // monitor: buffer/mapper models plus per-cycle protocol checks
  int         cyc = 0, n_done = 0, n_bwe = 0, n_we_rise = 0, falls = 0;
  int         t_we = 0, t_err = 0;
  int         n_done_b = 0, n_bwe_b = 0;
  logic [7:0] addr_hold, wdat_hold, bwe_addr_b, bwe_data_b;
  logic       we_prev = 1'b0, err_prev = 1'b0;
  always @(negedge clk) begin
    cyc++;
    if (!rst_n) begin
      we_prev = 1'b0; err_prev = 1'b0; falls = 0;
    end else begin
      if (buf_we) begin
        bufm[buf_addr] = buf_wdat;
        n_bwe++;
      end
      if (done) n_done++;
      if (err && !err_prev) t_err = cyc;
      err_prev = err;
      if (ss_we) begin
        check("we_needs_act", ss_act, 1'b1);
        if (we_prev) begin
          check("addr_stable", ss_addr, addr_hold);
          check("wdat_stable", ss_wdat, wdat_hold);
        end else begin
          addr_hold = ss_addr; wdat_hold = ss_wdat; falls = 0;
          t_we = cyc; n_we_rise++;
          check("wdat_vs_buf", ss_wdat, bufm[ss_addr]);
        end
        if (m2_fall) begin
          mreg[ss_addr] = ss_wdat;
          falls++;
        end
      end else if (we_prev && !err) begin
        check("falls_per_reg", falls, 2);
      end
      we_prev = ss_we;
      if (buf_we_b) begin
        n_bwe_b++; bwe_addr_b = buf_addr_b; bwe_data_b = buf_wdat_b;
      end
      if (done_b) n_done_b++;
    end
  end

  task automatic run_seq(input logic d, input int extra_at, input int budget);
    logic ok;
    @(posedge clk); #1; dir = d; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    ok = 1'b0;
    for (int k = 0; k < budget; k++) begin
      @(negedge clk);
      if (k == extra_at) begin start = 1'b1; dir = ~d; end
      else begin start = 1'b0; dir = d; end
      if (done || err) begin ok = 1'b1; break; end
    end
    start = 1'b0;
    check("seq_finished", ok, 1'b1);
    repeat (4) @(negedge clk);
    #1;
  endtask

  task automatic clear_counts();
    n_done = 0; n_bwe = 0; n_we_rise = 0;
  endtask

  logic [7:0] keep14;
  logic       ok6;

  initial begin
    start = 1'b0; dir = 1'b0; start_b = 1'b0; map_idx = 8'h00;
    for (int i = 0; i < 256; i++) begin mreg[i] = 8'h00; bufm[i] = 8'h00; end
    repeat (3) @(posedge clk); #1;
    check("rst_ss_act", ss_act, 1'b0);
    check("rst_ss_we", ss_we, 1'b0);
    check("rst_ss_addr", ss_addr, 8'd0);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_err", err, 1'b0);
    check("rst_buf_rd", buf_rd, 1'b0);
    check("rst_buf_we", buf_we, 1'b0);
    check("rst_ss_addr_b", ss_addr_b, 8'd127);
    @(negedge clk); rst_n = 1'b1;

    // directed save: mapper holds addr^A5
    for (int i = 0; i < 256; i++) begin mreg[i] = 8'(i) ^ 8'hA5; bufm[i] = 8'h00; end
    clear_counts();
    run_seq(1'b0, -1, 4000);
    check("save_done_cnt", n_done, 1);
    check("save_bwe_cnt", n_bwe, 14);
    check("save_err", err, 1'b0);
    check("save_busy_after", busy, 1'b0);
    check("save_act_after", ss_act, 1'b0);
    check("save_addr_after", ss_addr, 8'd0);
    for (int i = 0; i < 14; i++) check($sformatf("save_data[%0d]", i), bufm[i], 8'(i) ^ 8'hA5);
    check("save_past_last", bufm[14], 8'h00);

    // directed load: buffer holds 10+addr, latency 3, m2 every 6 clk
    for (int i = 0; i < 256; i++) begin bufm[i] = 8'h10 + 8'(i); mreg[i] = 8'h00; end
    clear_counts();
    run_seq(1'b1, -1, 4000);
    check("load_done_cnt", n_done, 1);
    check("load_err", err, 1'b0);
    check("load_we_rises", n_we_rise, 14);
    check("load_we_after", ss_we, 1'b0);
    for (int i = 0; i < 14; i++) check($sformatf("load_data[%0d]", i), mreg[i], 8'h10 + 8'(i));
    check("load_past_last", mreg[14], 8'h00);

    // random load: random data, latency and m2 period, stray buf_rdy
    for (int i = 0; i < 256; i++) begin bufm[i] = 8'($urandom); mreg[i] = 8'($urandom); end
    keep14 = mreg[14];
    lat_rand = 1'b1; spur_en = 1'b1; m2_per = $urandom_range(3, 9);
    clear_counts();
    run_seq(1'b1, -1, 6000);
    check("rload_done_cnt", n_done, 1);
    check("rload_err", err, 1'b0);
    for (int i = 0; i < 14; i++) check($sformatf("rload_data[%0d]", i), mreg[i], bufm[i]);
    check("rload_past_last", mreg[14], keep14);
    lat_rand = 1'b0; spur_en = 1'b0; m2_per = 6;

    // timeout: m2 stops while register 5 is being loaded
    for (int i = 0; i < 256; i++) begin bufm[i] = 8'h40 + 8'(i); mreg[i] = 8'h00; end
    clear_counts();
    m2_kill = 1'b1;
    run_seq(1'b1, -1, 4000);
    check("tmo_err", err, 1'b1);
    check("tmo_busy", busy, 1'b0);
    check("tmo_we", ss_we, 1'b0);
    check("tmo_act", ss_act, 1'b0);
    check("tmo_buf_rd", buf_rd, 1'b0);
    check("tmo_no_done", n_done, 0);
    check("tmo_latency", t_err - t_we, TMO_T);
    for (int i = 0; i < 5; i++) check($sformatf("tmo_data[%0d]", i), mreg[i], 8'h40 + 8'(i));
    check("tmo_reg5_untouched", mreg[5], 8'h00);
    m2_kill = 1'b0;

    // random save with a start pulse (and flipped dir) while busy
    for (int i = 0; i < 256; i++) begin mreg[i] = 8'($urandom); bufm[i] = 8'h00; end
    m2_per = $urandom_range(3, 9);
    clear_counts();
    run_seq(1'b0, 20, 4000);
    check("rsave_err_cleared", err, 1'b0);
    repeat (40) @(negedge clk);
    #1;
    check("rsave_done_cnt", n_done, 1);
    check("rsave_bwe_cnt", n_bwe, 14);
    check("rsave_busy", busy, 1'b0);
    for (int i = 0; i < 14; i++) check($sformatf("rsave_data[%0d]", i), bufm[i], mreg[i]);
    m2_per = 6;

    // reset while the mapper write is held in its latch period
    for (int i = 0; i < 256; i++) bufm[i] = 8'($urandom);
    @(posedge clk); #1; dir = 1'b1; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    ok6 = 1'b0;
    for (int k = 0; k < 2000; k++) begin
      @(negedge clk); #1;
      if (ss_we && falls == 1) begin ok6 = 1'b1; break; end
    end
    check("reach_latch", ok6, 1'b1);
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    check("arst_we", ss_we, 1'b0);
    check("arst_act", ss_act, 1'b0);
    check("arst_busy", busy, 1'b0);
    check("arst_addr", ss_addr, 8'd0);
    check("arst_wdat", ss_wdat, 8'd0);
    check("arst_buf_rd", buf_rd, 1'b0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 256; i++) bufm[i] = 8'($urandom);
    clear_counts();
    run_seq(1'b1, -1, 4000);
    check("post_rst_done", n_done, 1);
    check("post_rst_err", err, 1'b0);
    for (int i = 0; i < 14; i++) check($sformatf("post_rst_data[%0d]", i), mreg[i], bufm[i]);

    // single-register range at the map_idx slot
    map_idx = 8'($urandom);
    n_done_b = 0; n_bwe_b = 0;
    @(posedge clk); #1; start_b = 1'b1;
    @(posedge clk); #1; start_b = 1'b0;
    ok6 = 1'b0;
    for (int k = 0; k < 500; k++) begin
      @(negedge clk);
      if (done_b) begin ok6 = 1'b1; break; end
    end
    check("b_finished", ok6, 1'b1);
    repeat (4) @(negedge clk);
    #1;
    check("b_bwe_cnt", n_bwe_b, 1);
    check("b_bwe_addr", bwe_addr_b, 8'd0);
    check("b_bwe_data", bwe_data_b, map_idx);
    check("b_done_cnt", n_done_b, 1);
    check("b_err", err_b, 1'b0);
    check("b_busy", busy_b, 1'b0);
    check("b_act", ss_act_b, 1'b0);
    check("b_we", ss_we_b, 1'b0);
    check("b_buf_rd", buf_rd_b, 1'b0);
    check("b_wdat", ss_wdat_b, 8'h00);
    check("b_addr", ss_addr_b, 8'd127);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
